frequency_band_analyzer: RTL and testbench

Multi-channel successor to the two-frequency analyzer. Measures the period of a 1-bit sampled input (e.g. an FSK or modulated line) and counts full periods falling into each of `CHANNELS` independently programmable period bands over a fixed measurement window. Per-channel results are published once per window. It sits between the raw input pin and the register or decision logic that consumes frequency statistics.

---
 rtl/frequency_band_analyzer.sv | 153 +++++++++++++++
 tb/tb_frequency_band_analyzer.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frequency_band_analyzer.sv
// frequency_band_analyzer: measures input period and counts hits per programmable band over fixed windows
module frequency_band_analyzer #(
    parameter int CHANNELS      = 4,
    parameter int PERIOD_WIDTH  = 24,
    parameter int COUNTER_WIDTH = 32,
    parameter int WINDOW_CYCLES = 50000000,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              enable,
    input  logic                              clear,
    input  logic                              sample_data,
    input  logic [CHANNELS*PERIOD_WIDTH-1:0]  period_min,
    input  logic [CHANNELS*PERIOD_WIDTH-1:0]  period_max,
    output logic [CHANNELS*COUNTER_WIDTH-1:0] counts,
    output logic                              counts_valid,
    output logic [PERIOD_WIDTH-1:0]           last_period,
    output logic                              overflow
);
    localparam int WW = $clog2(WINDOW_CYCLES);
    localparam logic [WW-1:0] WIN_LAST = WW'(WINDOW_CYCLES - 1);
    localparam logic [PERIOD_WIDTH-1:0] P_MAX = {PERIOD_WIDTH{1'b1}};
    localparam logic [COUNTER_WIDTH-1:0] C_MAX = {COUNTER_WIDTH{1'b1}};

    logic [SYNC_STAGES-1:0]   sync;
    logic                     sync_prev;
    logic                     rise;
    logic                     run;
    logic                     armed;
    logic                     period_sat;
    logic                     period_ok;
    logic                     win_end;
    logic [PERIOD_WIDTH-1:0]  period_cnt;
    logic                     pend_valid;
    logic [PERIOD_WIDTH-1:0]  pend_period;
    logic [WW-1:0]            win_cnt;
    logic [COUNTER_WIDTH-1:0] acc [CHANNELS];
    logic [COUNTER_WIDTH-1:0] acc_next [CHANNELS];
    logic [CHANNELS-1:0]      hit;
    logic [CHANNELS-1:0]      at_max;
    logic                     ovf_hit;

    // input synchronizer plus one delayed copy for edge detection
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync      <= '0;
            sync_prev <= 1'b0;
        end else begin
            sync      <= {sync[SYNC_STAGES-2:0], sample_data};
            sync_prev <= sync[SYNC_STAGES-1];
        end
    end

    // edge qualification and window-end decode
    always_comb begin
        run        = enable & ~clear;
        rise       = sync[SYNC_STAGES-1] & ~sync_prev;
        period_sat = period_cnt == P_MAX;
        period_ok  = run & rise & armed & ~period_sat;
        win_end    = run & (win_cnt == WIN_LAST);
    end

    // period counter and armed flag: a period is only trusted between two edges seen while armed
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            period_cnt <= '0;
            armed      <= 1'b0;
        end else if (clear) begin
            period_cnt <= '0;
            armed      <= 1'b0;
        end else if (!enable) begin
            armed <= 1'b0;
        end else if (rise) begin
            period_cnt <= PERIOD_WIDTH'(1);
            armed      <= 1'b1;
        end else if (period_sat) begin
            armed <= 1'b0;
        end else begin
            period_cnt <= period_cnt + PERIOD_WIDTH'(1);
        end
    end

    // registered compare stage: holds the measured period for one cycle before classification
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pend_valid  <= 1'b0;
            pend_period <= '0;
        end else begin
            pend_valid <= period_ok;
            if (period_ok)
                pend_period <= period_cnt;
        end
    end

    // band classification against live bounds and saturating accumulator next-state
    always_comb begin
        hit      = '0;
        at_max   = '0;
        acc_next = acc;
        ovf_hit  = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            hit[i]      = pend_valid
                        & (pend_period >= period_min[i*PERIOD_WIDTH +: PERIOD_WIDTH])
                        & (pend_period <= period_max[i*PERIOD_WIDTH +: PERIOD_WIDTH]);
            at_max[i]   = acc[i] == C_MAX;
            acc_next[i] = win_end ? COUNTER_WIDTH'(hit[i])
                                  : acc[i] + COUNTER_WIDTH'(hit[i] & ~at_max[i]);
            ovf_hit     = ovf_hit | (hit[i] & at_max[i] & ~win_end);
        end
    end

    // window counter: wraps on the last enabled cycle of each window
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            win_cnt <= '0;
        else if (clear)
            win_cnt <= '0;
        else if (enable)
            win_cnt <= win_end ? '0 : win_cnt + WW'(1);
    end

    // accumulators, published counts and status outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < CHANNELS; i++)
                acc[i] <= '0;
            counts       <= '0;
            counts_valid <= 1'b0;
            last_period  <= '0;
            overflow     <= 1'b0;
        end else begin
            counts_valid <= win_end;
            if (clear) begin
                for (int i = 0; i < CHANNELS; i++)
                    acc[i] <= '0;
                counts      <= '0;
                last_period <= '0;
                overflow    <= 1'b0;
            end else if (enable) begin
                for (int i = 0; i < CHANNELS; i++) begin
                    acc[i] <= acc_next[i];
                    if (win_end)
                        counts[i*COUNTER_WIDTH +: COUNTER_WIDTH] <= acc[i];
                end
                if (pend_valid)
                    last_period <= pend_period;
                if (ovf_hit)
                    overflow <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_frequency_band_analyzer.sv
// tb_frequency_band_analyzer: randomized bench checked against an edge-timestamp reference model
`timescale 1ns/1ps
module tb_frequency_band_analyzer;
    localparam int CH = 2;
    localparam int PW = 8;
    localparam int W  = 1000;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic enable = 1'b0;
    logic clear = 1'b0;
    logic sample_data = 1'b0;
    logic [CH*PW-1:0] period_min = '0;
    logic [CH*PW-1:0] period_max = '0;
    logic [CH*8-1:0] counts_a;
    logic [CH*4-1:0] counts_b;
    logic valid_a, valid_b, ovf_a, ovf_b;
    logic [PW-1:0] last_a, last_b;

    int checks = 0;
    int failures = 0;
    int per = 0;
    int ph = 0;
    int gap = 0;

    // reference model state: absolute edge number, time of the last arming edge, windowed tallies
    int e_no = 0;
    int rise_at = -1;
    int pend = 0;
    int pend_p = 0;
    int win = 0;
    int m_last = 0;
    int m_pulse = 0;
    int m_ovf_a = 0;
    int m_ovf_b = 0;
    int acc_a[CH], acc_b[CH], cnt_a[CH], cnt_b[CH];
    bit s1, s2, s3;

    always #5 clock = ~clock;

    frequency_band_analyzer #(.CHANNELS(CH), .PERIOD_WIDTH(PW), .COUNTER_WIDTH(8),
                              .WINDOW_CYCLES(W), .SYNC_STAGES(2)) dut_a (
        .clock(clock), .reset(reset), .enable(enable), .clear(clear), .sample_data(sample_data),
        .period_min(period_min), .period_max(period_max), .counts(counts_a),
        .counts_valid(valid_a), .last_period(last_a), .overflow(ovf_a));

    frequency_band_analyzer #(.CHANNELS(CH), .PERIOD_WIDTH(PW), .COUNTER_WIDTH(4),
                              .WINDOW_CYCLES(W), .SYNC_STAGES(2)) dut_b (
        .clock(clock), .reset(reset), .enable(enable), .clear(clear), .sample_data(sample_data),
        .period_min(period_min), .period_max(period_max), .counts(counts_b),
        .counts_valid(valid_b), .last_period(last_b), .overflow(ovf_b));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic model_zero();
        win = 0; rise_at = -1; pend = 0; m_last = 0; m_pulse = 0; m_ovf_a = 0; m_ovf_b = 0;
        for (int c = 0; c < CH; c++) begin
            acc_a[c] = 0; acc_b[c] = 0; cnt_a[c] = 0; cnt_b[c] = 0;
        end
    endtask

    task automatic model_reset();
        model_zero();
        s1 = 0; s2 = 0; s3 = 0;
    endtask

    // one clock edge of the model; a period is the distance between consecutive detected edges
    task automatic model_step();
        bit r;
        int h;
        r = s2 & ~s3;
        m_pulse = 0;
        if (clear) begin
            model_zero();
        end else if (enable) begin
            for (int c = 0; c < CH; c++) begin
                h = (pend != 0 && period_min[c*PW +: PW] <= pend_p && pend_p <= period_max[c*PW +: PW]) ? 1 : 0;
                if (win == W - 1) begin
                    cnt_a[c] = acc_a[c]; cnt_b[c] = acc_b[c];
                    acc_a[c] = h; acc_b[c] = h;
                end else if (h == 1) begin
                    if (acc_a[c] == 255) m_ovf_a = 1; else acc_a[c]++;
                    if (acc_b[c] == 15) m_ovf_b = 1; else acc_b[c]++;
                end
            end
            if (pend != 0) m_last = pend_p;
            if (win == W - 1) begin
                m_pulse = 1;
                win = 0;
            end else begin
                win++;
            end
            pend = 0;
            if (r) begin
                if (rise_at >= 0 && e_no - rise_at <= 254) begin
                    pend = 1;
                    pend_p = e_no - rise_at;
                end
                rise_at = e_no;
            end
        end else begin
            rise_at = -1;
            pend = 0;
        end
        s3 = s2; s2 = s1; s1 = sample_data;
        e_no++;
    endtask

    task automatic check_all();
        check("pulse_a", valid_a, m_pulse);
        check("pulse_b", valid_b, m_pulse);
        for (int c = 0; c < CH; c++) begin
            check($sformatf("counts_a%0d", c), counts_a[c*8 +: 8], cnt_a[c]);
            check($sformatf("counts_b%0d", c), counts_b[c*4 +: 4], cnt_b[c]);
        end
        check("last_period_a", last_a, m_last);
        check("last_period_b", last_b, m_last);
        check("overflow_a", ovf_a, m_ovf_a);
        check("overflow_b", ovf_b, m_ovf_b);
    endtask

    task automatic tick();
        @(posedge clock);
        if (reset) model_step(); else model_reset();
        #1;
        if (m_pulse != 0 || valid_a || valid_b) check_all();
        if (per > 0) begin
            ph = (ph + 1) % per;
            sample_data = ph < per / 2;
        end else begin
            sample_data = 1'b0;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_pulse();
        for (int n = 0; n < 3 * W; n++) begin
            tick();
            if (valid_a) return;
        end
        check("pulse_timeout", valid_a, 1);
    endtask

    task automatic measure(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!valid_a && n < 3 * W);
    endtask

    task automatic set_band(input int c, input int lo, input int hi);
        period_min[c*PW +: PW] = PW'(lo);
        period_max[c*PW +: PW] = PW'(hi);
    endtask

    initial begin
        model_reset();
        #2 reset = 1'b0;
        per = 7;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("reset_pulse", valid_a, 0);
        end
        check("reset_counts", counts_a, 0);
        check("reset_last", last_a, 0);
        check("reset_ovf", ovf_b, 0);
        reset = 1'b1;
        set_band(0, 18, 22);
        set_band(1, 40, 60);
        enable = 1'b1;
        per = 20; ph = 0;

        wait_pulse();
        wait_pulse();
        measure(gap);
        check("pulse_spacing", gap, W);
        check("p20_ch0", counts_a[7:0], 50);
        check("p20_ch1", counts_a[15:8], 0);
        check("p20_last", last_a, 20);
        check("sat_ch0", counts_b[3:0], 15);
        check("sat_ovf_b", ovf_b, 1);
        check("sat_ovf_a", ovf_a, 0);

        per = 50; ph = ph % per;
        wait_pulse();
        wait_pulse();
        check("p50_ch0", counts_a[7:0], 0);
        check("p50_ch1", counts_a[15:8], 20);

        set_band(1, 15, 25);
        per = 20; ph = ph % per;
        wait_pulse();
        wait_pulse();
        check("overlap_ch0", counts_a[7:0], 50);
        check("overlap_ch1", counts_a[15:8], 50);

        run(60);
        per = 0;
        run(300);
        per = 30; ph = 29;
        run(10);
        check("timeout_hold", last_a, 20);
        run(30);
        check("timeout_resume", last_a, 30);
        check_all();

        per = 20; ph = 0;
        wait_pulse();
        run(500);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clear_counts", counts_a, 0);
        check("clear_last", last_a, 0);
        check("clear_ovf", ovf_b, 0);
        measure(gap);
        check("clear_spacing", gap, W);

        run(999);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clear_at_end_pulse", valid_a, 0);
        check("clear_at_end_counts", counts_a, 0);

        wait_pulse();
        run(300);
        enable = 1'b0;
        run(200);
        enable = 1'b1;
        measure(gap);
        check("enable_gap", gap, W - 300);
        check_all();

        for (int it = 0; it < 8; it++) begin
            int len;
            for (int c = 0; c < CH; c++) begin
                int lo;
                lo = $urandom_range(6, 60);
                if ($urandom_range(0, 4) == 0) set_band(c, lo, lo - 3);
                else set_band(c, lo, lo + $urandom_range(0, 30));
            end
            per = $urandom_range(6, 80);
            ph = ph % per;
            len = $urandom_range(800, 2000);
            for (int n = 0; n < len; n++) begin
                if ($urandom_range(0, 399) == 0) begin
                    enable = 1'b0;
                    run($urandom_range(1, 50));
                    enable = 1'b1;
                end
                if ($urandom_range(0, 1499) == 0) begin
                    clear = 1'b1;
                    tick();
                    clear = 1'b0;
                end
                tick();
            end
            check_all();
        end

        per = 20; ph = 0;
        set_band(0, 18, 22);
        wait_pulse();
        run(400);
        reset = 1'b0;
        #2;
        check("async_reset_counts", counts_a, 0);
        check("async_reset_last", last_a, 0);
        check("async_reset_ovf", ovf_b, 0);
        model_reset();
        run(3);
        reset = 1'b1;
        wait_pulse();
        check_all();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
